b10_display_scan: RTL

//  Time-multiplexed 7-segment driver for a chain of one-digit base-10 counters.

---
 rtl/b10_display_scan_pkg.sv | 25 ++
 rtl/b10_display_scan_decode.sv | 26 ++
 rtl/b10_display_scan.sv | 106 ++++++++++
 3 files changed

// File: rtl/b10_display_scan_pkg.sv
// Shared constants for the base-10 display scanner: BCD width and 7-segment glyphs.
package b10_display_scan_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  // Segment bit0=a .. bit6=g, active high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] code);
    return code > 4'd9;
  endfunction

endpackage

// File: rtl/b10_display_scan_decode.sv
// Combinational BCD to 7-segment decoder; codes above 9 render as a dash.
module bcd_to_7seg
  import b10_display_scan_pkg::*;
(
  input  logic [BCD_W-1:0] code_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/b10_display_scan.sv
// Time-multiplexed 7-segment driver: snapshots N packed BCD digits on load and
// scans them one digit per SCAN_DIV clocks, with optional leading-zero blanking.
module b10_display_scan
  import b10_display_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                      clock,
  input  logic                      reset_,
  input  logic [BCD_W*N_DIGITS-1:0] digits,
  input  logic                      load,
  output logic [SEG_W-1:0]          seg,
  output logic [N_DIGITS-1:0]       an_,
  output logic                      err
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PW-1:0]             presc_q, presc_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BCD_W*N_DIGITS-1:0] snap_q, snap_d;
  logic                      err_q, err_d;
  logic [SEG_W-1:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0]       an_q, an_d;

  logic                      tick;
  logic [BCD_W-1:0]          cur_code;
  logic [SEG_W-1:0]          cur_seg;
  logic [N_DIGITS-1:0]       zero_sfx;
  logic                      zero_run;
  logic                      cur_blank;
  logic                      load_err;

  assign tick     = (presc_q == PW'(SCAN_DIV - 1));
  assign cur_code = snap_q[idx_q*BCD_W +: BCD_W];

  bcd_to_7seg u_dec (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  // zero_sfx[i] is set when snapshot digits i..N-1 are all zero
  always_comb begin
    zero_sfx = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      zero_run = zero_run && (snap_q[(N_DIGITS-1-k)*BCD_W +: BCD_W] == '0);
      zero_sfx[N_DIGITS-1-k] = zero_run;
    end
  end

  assign cur_blank = (BLANK_LZ != 0) && (idx_q != '0) && zero_sfx[idx_q];

  always_comb begin
    load_err = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      load_err = load_err | bcd_invalid(digits[k*BCD_W +: BCD_W]);
    end
  end

  // Display registers sample snap_q, so a load coinciding with a tick shows old data
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    seg_d   = seg_q;
    an_d    = an_q;
    if (tick) begin
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      an_d  = '1;
      if (cur_blank) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d       = cur_seg;
        an_d[idx_q] = 1'b0;
      end
    end
    snap_d = load ? digits   : snap_q;
    err_d  = load ? load_err : err_q;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      err_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an_ = an_q;
  assign err = err_q;

endmodule
